obm_dma: RTL and testbench
==========================

OBM_DMA -- requirements
Module: obm_dma

Interface
REQ-001 SHALL have parameter NUM_OBJECTS, default 64, number of 4-byte OBM entries copied per transfer (byte count N = 4*NUM_OBJECTS).
REQ-002 SHALL have parameter OBM_BASE, default 12'h800, VRAM address of OBM byte 0.
REQ-003 SHALL have port cpu_clk  input  1  sole clock; all state on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start_i  input  1  one-cycle transfer request.
REQ-006 SHALL have port src_page_i  input  8  source page; byte k is read from {src_page_i, 8'(k)}.
REQ-007 SHALL have port vblank_i  input  1  high while the GPU is in vertical blanking.
REQ-008 SHALL have ports mem_req_o output 1 / mem_addr_o output 16 / mem_ack_i input 1 / mem_data_i input mapache64::data_t, the main-memory read handshake.
REQ-009 SHALL have ports vram_address_o output mapache64::vram_address_t / data_o output mapache64::data_t / wen_o output 1 / SELECT_obm_o output 1, the VRAM write master.
REQ-010 SHALL have ports busy_o output 1 and done_o output 1, the status outputs.

Function
REQ-011 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-012 IDLE: when start_i=1, SHALL latch src_page_i, clear byte index idx to 0, and go to READ; in all other states start_i SHALL be ignored.
REQ-013 READ: SHALL hold mem_req_o=1 and mem_addr_o={page,idx}; on a cycle with mem_ack_i=1, SHALL latch mem_data_i and go to WRITE.
REQ-014 WRITE: SHALL drive wen_o=1, SELECT_obm_o=1, vram_address_o=OBM_BASE+idx, and data_o=latched byte for exactly one cycle, then go to READ with idx+1, or to DONE if idx==N-1.
REQ-015 DONE: SHALL assert done_o for exactly one cycle, then go to IDLE.
REQ-016 busy_o SHALL be 1 in READ, WRITE, and DONE, and 0 in IDLE.
REQ-017 wen_o and SELECT_obm_o SHALL be 0 outside a write cycle, and mem_req_o SHALL be 0 outside READ.
REQ-018 idx SHALL be 8 bits wide and SHALL never wrap within a transfer; N > 256 SHALL be rejected at elaboration with $error.
REQ-019 With mem_ack_i=1 in the same cycle as each request, throughput SHALL be 2 cycles per byte, and done_o SHALL occur 2N+1 cycles after the start_i cycle.
REQ-020 mem_ack_i outside READ SHALL be ignored.
REQ-021 A start_i coincident with done_o SHALL be ignored.

Reset
REQ-022 On rst_n=0, SHALL go to IDLE immediately and clear idx, the page register, and the data register.
REQ-023 During reset, all outputs SHALL be 0, and the block SHALL not resume any transfer interrupted by reset.

Configuration
REQ-024 With OBM_DMA_VBLANK_GATE_EN defined, WRITE SHALL stall with wen_o=0 and SELECT_obm_o=0 while vblank_i=0, and SHALL perform the write in the first cycle with vblank_i=1.
REQ-025 Without OBM_DMA_VBLANK_GATE_EN, vblank_i SHALL be ignored and writes SHALL never stall.

Structure
REQ-026 The state typedef obm_dma_state_t and the constant OBM_BASE_ADDR=12'h800 SHALL reside in package mapache64; the parameter OBM_BASE SHALL default to OBM_BASE_ADDR.
REQ-027 SHALL be a single module with no sub-module; the VRAM-side address/data mux is outside this block.

Verification
REQ-028 Reset is released and start_i is pulsed with src_page_i=8'h02 and immediate ack -> 256 writes to 12'h800..12'h8FF carrying the data at 16'h0200..16'h02FF; done_o is high at cycle 513; busy_o falls at cycle 514.
REQ-029 mem_ack_i is delayed 3 cycles per request -> mem_addr_o is stable while mem_req_o=1, each byte takes 5 cycles, and no wen_o is asserted during READ.
REQ-030 start_i is pulsed again at idx=10 -> it is ignored and the transfer completes unchanged.
REQ-031 rst_n is driven low at idx=100 -> all outputs are 0 immediately; after release, busy_o=0 until a new start_i.
REQ-032 With OBM_DMA_VBLANK_GATE_EN defined, vblank_i is held 0 for 20 cycles at idx=5 -> wen_o stays 0 for those 20 cycles, then the write to 12'h805 occurs in the first cycle with vblank_i=1.
REQ-033 NUM_OBJECTS=2 -> exactly 8 writes occur, to 12'h800..12'h807, and done_o is high at cycle 17.

Source files
------------

// File: rtl/mapache64.sv
// Shared mapache64 definitions: bus data/address types, the OBM DMA state
// encoding and the VRAM location of the object attribute memory (OBM).
package mapache64;

    typedef logic [7:0]  data_t;
    typedef logic [11:0] vram_address_t;

    localparam vram_address_t OBM_BASE_ADDR = 12'h800;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } obm_dma_state_t;

endpackage

// File: rtl/obm_dma.sv
// obm_dma -- copies N = 4*NUM_OBJECTS bytes from main-memory page src_page_i
// into the OBM region of VRAM, one read/write pair per byte.
//
// Ports:
//   cpu_clk, rst_n          clock, asynchronous active-low reset
//   start_i, src_page_i     transfer request and source page (sampled in IDLE)
//   vblank_i                GPU vertical blanking flag
//   mem_req_o/mem_addr_o    main-memory read request and address
//   mem_ack_i/mem_data_i    main-memory read acknowledge and data
//   vram_address_o, data_o  VRAM write address and byte
//   wen_o, SELECT_obm_o     VRAM write strobe and OBM select
//   busy_o, done_o          transfer in progress / one-cycle completion pulse
//
// Build option: OBM_DMA_VBLANK_GATE_EN holds each write until vblank_i=1.
module obm_dma
    import mapache64::*;
#(
    parameter int unsigned   NUM_OBJECTS = 64,
    parameter vram_address_t OBM_BASE    = OBM_BASE_ADDR
) (
    input  logic                     cpu_clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [7:0]               src_page_i,
    input  logic                     vblank_i,
    output logic                     mem_req_o,
    output logic [15:0]              mem_addr_o,
    input  logic                     mem_ack_i,
    input  mapache64::data_t         mem_data_i,
    output mapache64::vram_address_t vram_address_o,
    output mapache64::data_t         data_o,
    output logic                     wen_o,
    output logic                     SELECT_obm_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int unsigned N_BYTES  = 4 * NUM_OBJECTS;
    localparam logic [7:0]  LAST_IDX = 8'(N_BYTES - 1);

    // An 8-bit byte index must never wrap inside one transfer.
    if (N_BYTES > 256 || N_BYTES == 0) begin : g_size_check
        $error("obm_dma: 4*NUM_OBJECTS must be in 1..256");
    end

    obm_dma_state_t r_state;
    logic [7:0]     r_page;
    logic [7:0]     r_idx;
    data_t          r_data;
    logic           r_mem_req;
    logic [15:0]    r_mem_addr;
    vram_address_t  r_vram_addr;
    logic           r_wr;
    logic           r_busy;
    logic           r_done;

    logic           w_wr_ok;
    logic           w_wr_fire;
    logic [7:0]     w_idx_nxt;

`ifdef OBM_DMA_VBLANK_GATE_EN
    // Writes may only land while the GPU is not scanning VRAM.
    assign w_wr_ok = vblank_i;
`else
    logic w_unused_vblank;
    assign w_unused_vblank = vblank_i;
    assign w_wr_ok         = 1'b1;
`endif

    // r_wr is high for the whole WRITE state; the strobe fires only when allowed.
    assign w_wr_fire = r_wr & w_wr_ok;
    assign w_idx_nxt = r_idx + 8'd1;

    // Transfer FSM; every output register is updated on the transition that
    // enters the state it belongs to.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_page      <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_vram_addr <= '0;
            r_wr        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_page     <= src_page_i;
                        r_idx      <= 8'd0;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {src_page_i, 8'd0};
                        r_busy     <= 1'b1;
                        r_state    <= READ;
                    end
                end
                READ: begin
                    if (mem_ack_i) begin
                        r_data      <= mem_data_i;
                        r_mem_req   <= 1'b0;
                        r_wr        <= 1'b1;
                        r_vram_addr <= OBM_BASE + 12'(r_idx);
                        r_state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_wr_ok) begin
                        r_wr <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx      <= w_idx_nxt;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {r_page, w_idx_nxt};
                            r_state    <= READ;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o      = r_mem_req;
    assign mem_addr_o     = r_mem_addr;
    assign vram_address_o = r_vram_addr;
    assign data_o         = r_data;
    assign wen_o          = w_wr_fire;
    assign SELECT_obm_o   = w_wr_fire;
    assign busy_o         = r_busy;
    assign done_o         = r_done;

endmodule

// File: tb/tb_obm_dma.sv
// Bench for obm_dma: a random main-memory image, a responder with
// programmable ack latency and noise acks outside requests, and an expected
// write stream derived from page/byte-index arithmetic.
module tb_obm_dma;

    localparam int unsigned N_A = 256;

    logic        cpu_clk    = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start_i    = 1'b0;
    logic [7:0]  src_page_i = 8'h00;
    logic        vblank_i   = 1'b1;
    logic        mem_ack_i  = 1'b0;
    logic [7:0]  mem_data_i = 8'h00;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic [11:0] vram_address_o;
    logic [7:0]  data_o;
    logic        wen_o, SELECT_obm_o, busy_o, done_o;

    logic        start_b = 1'b0;
    logic        b_req, b_wen, b_sel, b_busy, b_done;
    logic [15:0] b_maddr;
    logic [11:0] b_vaddr;
    logic [7:0]  b_data_o, b_mdata;

    logic [7:0]  mem [0:65535];
    int          n_vec = 0;
    int          n_err = 0;
    int          rsp_dly = 0;

    obm_dma dut_a (
        .cpu_clk(cpu_clk), .rst_n(rst_n), .start_i(start_i), .src_page_i(src_page_i),
        .vblank_i(vblank_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .vram_address_o(vram_address_o),
        .data_o(data_o), .wen_o(wen_o), .SELECT_obm_o(SELECT_obm_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    obm_dma #(.NUM_OBJECTS(2)) dut_b (
        .cpu_clk(cpu_clk), .rst_n(rst_n), .start_i(start_b), .src_page_i(8'h35),
        .vblank_i(1'b1), .mem_req_o(b_req), .mem_addr_o(b_maddr),
        .mem_ack_i(1'b1), .mem_data_i(b_mdata), .vram_address_o(b_vaddr),
        .data_o(b_data_o), .wen_o(b_wen), .SELECT_obm_o(b_sel),
        .busy_o(b_busy), .done_o(b_done)
    );

    assign b_mdata = mem[b_maddr];

    initial forever #5 cpu_clk = ~cpu_clk;

    // Main-memory responder: acks after rsp_dly waiting cycles; random noise otherwise.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge cpu_clk);
            if (mem_req_o) begin
                if (cnt >= rsp_dly) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = mem[mem_addr_o];
                end else begin
                    mem_ack_i  = 1'b0;
                    mem_data_i = 8'($urandom);
                end
                cnt++;
            end else begin
                mem_ack_i  = 1'($urandom);
                mem_data_i = 8'($urandom);
                cnt        = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, {4'h0, mem_addr_o, vram_address_o}, 32'h0);
        check({tag, "_ctl"}, {data_o, mem_req_o, wen_o, SELECT_obm_o, busy_o, done_o}, 32'h0);
    endtask

    // One transfer on dut_a, checked cycle by cycle against the expected stream.
    task automatic run_xfer(input logic [7:0] page, input int dly, input int glitch_at,
                            input int rst_at, input int stall_at, input bit poke_done,
                            input int exp_done);
        int          n, wr, stall_left;
        bit          glitched, stalled, aborted, expect_now;
        logic        prev_req;
        logic [15:0] prev_addr;
        n = 1; wr = 0; stall_left = 0;
        glitched = 0; stalled = 0; aborted = 0; expect_now = 0;
        prev_req = 1'b0; prev_addr = 16'h0;
        rsp_dly = dly;
        @(negedge cpu_clk);
        start_i = 1'b1; src_page_i = page;
        @(negedge cpu_clk);
        start_i = 1'b0; src_page_i = 8'($urandom);
        while (!done_o && n < 2000 && !aborted) begin
            check("busy_run", busy_o, 1);
            check("sel_vs_wen", SELECT_obm_o, wen_o);
            if (mem_req_o) begin
                check("rd_addr", mem_addr_o, {page, 8'(wr)});
                check("wen_in_read", wen_o, 0);
                if (prev_req) check("addr_stable", mem_addr_o, prev_addr);
            end
            if (stall_left > 0) check("stall_wen", wen_o, 0);
            if (expect_now) begin
                check("stall_release_wen", wen_o, 1);
                check("stall_release_addr", vram_address_o, 12'h800 + 12'(stall_at));
                expect_now = 0;
            end
            if (wen_o) begin
                check("wr_addr", vram_address_o, 12'h800 + 12'(wr));
                check("wr_data", data_o, mem[{page, 8'(wr)}]);
                check("wr_in_range", (wr < N_A), 1);
                wr++;
            end
            prev_req  = mem_req_o;
            prev_addr = mem_addr_o;
            if (rst_at >= 0 && wr == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_zero("rst_mid");
                aborted = 1;
            end else begin
                if (glitch_at >= 0 && wr == glitch_at && !glitched) begin
                    start_i = 1'b1; src_page_i = ~page; glitched = 1;
                end else begin
                    start_i = 1'b0;
                end
`ifdef OBM_DMA_VBLANK_GATE_EN
                if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) begin
                        vblank_i = 1'b1; expect_now = 1;
                    end
                end else if (stall_at >= 0 && wr == stall_at && !stalled) begin
                    vblank_i = 1'b0; stall_left = 20; stalled = 1;
                end
`else
                vblank_i = 1'($urandom);
`endif
                @(negedge cpu_clk);
                n++;
            end
        end
        if (aborted) return;
        check("done_seen", done_o, 1);
        check("done_cycle", n, exp_done);
        check("write_total", wr, N_A);
        if (poke_done) begin
            start_i = 1'b1; src_page_i = 8'($urandom);
        end
        @(negedge cpu_clk);
        start_i = 1'b0;
        check("done_pulse", done_o, 0);
        check("busy_fall", busy_o, 0);
        if (poke_done) begin
            @(negedge cpu_clk);
            check("poke_ignored", {busy_o, mem_req_o}, 0);
        end
    endtask

    initial begin
        int d, bn, bwr;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge cpu_clk);
        check_zero("rst_init");
        check({"rst_init", "_b"}, {b_req, b_wen, b_sel, b_busy, b_done}, 0);
        rst_n = 1'b1;
        @(negedge cpu_clk);

        // Full-size transfer from page 2 with same-cycle ack; start at done ignored.
        run_xfer(8'h02, 0, -1, -1, -1, 1'b1, 2 * N_A + 1);
        // Three-cycle ack latency: five cycles per byte.
        run_xfer(8'($urandom), 3, -1, -1, -1, 1'b0, 5 * N_A + 1);
        // Second start at idx 10 must not disturb the transfer.
        run_xfer(8'($urandom), 0, 10, -1, -1, 1'b0, 2 * N_A + 1);
        d = $urandom_range(0, 2);
        run_xfer(8'($urandom), d, -1, -1, -1, 1'b0, (2 + d) * N_A + 1);

        // Reset in the middle of a transfer.
        run_xfer(8'($urandom), 0, -1, 100, -1, 1'b0, 0);
        start_i = 1'b0;
        repeat (3) begin
            @(negedge cpu_clk);
            check_zero("rst_hold");
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge cpu_clk);
            check("post_rst_idle", {busy_o, mem_req_o, wen_o}, 0);
        end
        run_xfer(8'($urandom), 1, -1, -1, -1, 1'b0, 3 * N_A + 1);

`ifdef OBM_DMA_VBLANK_GATE_EN
        // 20 cycles without vblank once idx reaches 5.
        run_xfer(8'($urandom), 0, -1, -1, 5, 1'b0, 2 * N_A + 1 + 19);
`endif

        // Small instance: NUM_OBJECTS=2 gives 8 bytes from page 0x35.
        @(negedge cpu_clk);
        start_b = 1'b1;
        @(negedge cpu_clk);
        start_b = 1'b0;
        bn = 1; bwr = 0;
        while (!b_done && bn < 200) begin
            if (b_wen) begin
                check("b_wr_addr", b_vaddr, 12'h800 + 12'(bwr));
                check("b_wr_data", b_data_o, mem[{8'h35, 8'(bwr)}]);
                bwr++;
            end
            @(negedge cpu_clk);
            bn++;
        end
        check("b_done_seen", b_done, 1);
        check("b_done_cycle", bn, 17);
        check("b_write_total", bwr, 8);
        @(negedge cpu_clk);
        check("b_busy_fall", b_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
